dram_arbiter: RTL and testbench
===============================

DRAM_ARBITER -- requirements
Module: dram_arbiter

Interface
REQ-001 SHALL have parameter BURST_LEN, default 8, words per DRAM transfer (one cache block).
REQ-002 SHALL have parameter CNT_W, default 4, beat-counter width; it SHALL hold BURST_LEN.
REQ-003 CLK  in  1  clock; all state updates on rising edge.
REQ-004 RESET  in  1  reset, asynchronous, active-low.
REQ-005 I_req  in  1  I-cache fill request; held high until the burst completes.
REQ-006 I_addr  in  32  I-cache block word address; stable while I_req is high.
REQ-007 I_data  out  32  read data to the I-cache.
REQ-008 I_valid  out  1  I_data beat valid.
REQ-009 D_req  in  1  D-cache request (fill or write-back); held high until the burst completes.
REQ-010 D_we  in  1  1 = write-back, 0 = fill; stable while D_req is high.
REQ-011 D_addr  in  32  D-cache block word address.
REQ-012 D_wdata  in  32  write-back word presented by the D-cache.
REQ-013 D_wnext  out  1  write beat accepted; D-cache advances D_wdata next cycle.
REQ-014 D_data  out  32  read data to the D-cache.
REQ-015 D_valid  out  1  D_data beat valid.
REQ-016 DRAM_cmd  out  1  one-cycle command strobe.
REQ-017 DRAM_we  out  1  command and beats are writes.
REQ-018 DRAM_addr  out  32  registered block address of the current command.
REQ-019 DRAM_wdata  out  32  write data, equal to D_wdata during write grant.
REQ-020 DRAM_rdata  in  32  read data beat.
REQ-021 DRAM_rvalid  in  1  read beat valid.
REQ-022 DRAM_wready  in  1  DRAM accepts the current write beat.
REQ-023 busy  out  1  high in every state except IDLE.

Function
REQ-024 FSM states SHALL be IDLE, CMD, XFER, RELEASE.
REQ-025 IDLE: on any request, SHALL register the winner, its address and its direction; go to CMD next edge.
REQ-026 Arbitration SHALL be round-robin on a last_grant register: a single requester wins alone; on a tie, the side not in last_grant wins.
REQ-027 CMD SHALL last exactly one cycle: DRAM_cmd=1, DRAM_addr/DRAM_we from registers; then go to XFER.
REQ-028 XFER read: each DRAM_rvalid SHALL pass DRAM_rdata combinationally to the granted side's data output and assert its valid in the same cycle; the other side's valid SHALL stay 0.
REQ-029 XFER write: D_wnext SHALL equal DRAM_wready; DRAM_wdata SHALL equal D_wdata.
REQ-030 The beat counter SHALL increment per accepted beat; at the BURST_LEN-th beat it SHALL clear and the FSM SHALL go to RELEASE.
REQ-031 RELEASE SHALL hold until the granted requester's req is low (minimum one cycle), then go to IDLE; the granted req SHALL NOT be re-arbitrated while high.
REQ-032 The ungranted request SHALL remain pending and SHALL win the next arbitration after RELEASE.
REQ-033 DRAM_rvalid or DRAM_wready outside XFER, or of the wrong direction, SHALL be ignored: no valid/wnext, no count.
REQ-034 Requester req dropping in CMD/XFER is illegal; the arbiter SHALL still complete BURST_LEN beats.
REQ-035 last_grant SHALL update on entry to CMD.

Reset
REQ-036 RESET low SHALL force IDLE immediately, including mid-burst, and clear the counter.
REQ-037 Reset values: DRAM_cmd, DRAM_we, I_valid, D_valid, D_wnext, busy = 0; DRAM_addr = 0; last_grant = I (D wins the first tie).
REQ-038 After reset release, no DRAM_cmd SHALL issue without a new request.

Verification
REQ-039 I_req=1, I_addr=0x40 alone -> DRAM_cmd one cycle with addr 0x40, we=0; 8 rvalid beats -> 8 I_valid pulses with matching data, D_valid=0.
REQ-040 I_req and D_req (we=0) rise together after reset -> D granted first; after D_req drops, I granted with I_addr.
REQ-041 D_req=1, D_we=1, DRAM_wready toggled 1,0,1,... -> 8 D_wnext pulses exactly on wready cycles; RELEASE after the 8th.
REQ-042 DRAM_rvalid pulses in IDLE -> no I_valid/D_valid and no counter change.
REQ-043 RESET low after beat 4 of a read -> busy=0 asynchronously; a new request then gets full 8-beat service.
REQ-044 I_req held 2 cycles after beat 8 -> no second DRAM_cmd until I_req low, then IDLE.

Source files
------------

// File: rtl/dram_arbiter.sv
// Two-port DRAM arbiter: I-cache and D-cache share one burst channel.
// Round-robin grant, one-cycle command strobe, BURST_LEN-beat transfers.
module dram_arbiter #(
   parameter int BURST_LEN = 8,
   parameter int CNT_W     = 4
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        I_req,
   input  logic [31:0] I_addr,
   output logic [31:0] I_data,
   output logic        I_valid,
   input  logic        D_req,
   input  logic        D_we,
   input  logic [31:0] D_addr,
   input  logic [31:0] D_wdata,
   output logic        D_wnext,
   output logic [31:0] D_data,
   output logic        D_valid,
   output logic        DRAM_cmd,
   output logic        DRAM_we,
   output logic [31:0] DRAM_addr,
   output logic [31:0] DRAM_wdata,
   input  logic [31:0] DRAM_rdata,
   input  logic        DRAM_rvalid,
   input  logic        DRAM_wready,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE,
      CMD,
      XFER,
      RELEASE
   } state_t;

   localparam logic [CNT_W-1:0] LAST = CNT_W'(BURST_LEN - 1);

   state_t           state;
   logic             gnt_d;
   logic             last_d;
   logic [CNT_W-1:0] cnt;

   logic win_d;
   logic any_req;
   logic gnt_req;
   logic xfer;
   logic beat;

   // D wins if alone, or on a tie when I held the last grant.
   assign any_req = I_req | D_req;
   assign win_d   = D_req & (~I_req | ~last_d);
   assign gnt_req = gnt_d ? D_req : I_req;
   assign xfer    = (state == XFER);

   // Beats only count in XFER and only in the granted direction.
   assign I_valid = xfer & ~DRAM_we & ~gnt_d & DRAM_rvalid;
   assign D_valid = xfer & ~DRAM_we & gnt_d & DRAM_rvalid;
   assign D_wnext = xfer & DRAM_we & DRAM_wready;
   assign beat    = I_valid | D_valid | D_wnext;

   assign I_data     = DRAM_rdata;
   assign D_data     = DRAM_rdata;
   assign DRAM_wdata = D_wdata;

   // Grant FSM with registered command/address/busy outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state     <= IDLE;
         gnt_d     <= 1'b0;
         last_d    <= 1'b0;
         cnt       <= '0;
         DRAM_cmd  <= 1'b0;
         DRAM_we   <= 1'b0;
         DRAM_addr <= '0;
         busy      <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (any_req) begin
                  gnt_d     <= win_d;
                  last_d    <= win_d;
                  DRAM_addr <= win_d ? D_addr : I_addr;
                  DRAM_we   <= win_d & D_we;
                  DRAM_cmd  <= 1'b1;
                  busy      <= 1'b1;
                  state     <= CMD;
               end
            end
            CMD: begin
               DRAM_cmd <= 1'b0;
               state    <= XFER;
            end
            XFER: begin
               if (beat) begin
                  if (cnt == LAST) begin
                     cnt   <= '0;
                     state <= RELEASE;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            RELEASE: begin
               if (!gnt_req) begin
                  busy  <= 1'b0;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter.
// Inputs change 1ns after posedge; checks 2ns later.
module tb_dram_arbiter;

   logic        CLK = 1'b0;
   logic        RESET = 1'b0;
   logic        I_req = 1'b0;
   logic [31:0] I_addr = '0;
   logic [31:0] I_data;
   logic        I_valid;
   logic        D_req = 1'b0;
   logic        D_we = 1'b0;
   logic [31:0] D_addr = '0;
   logic [31:0] D_wdata = '0;
   logic        D_wnext;
   logic [31:0] D_data;
   logic        D_valid;
   logic        DRAM_cmd;
   logic        DRAM_we;
   logic [31:0] DRAM_addr;
   logic [31:0] DRAM_wdata;
   logic [31:0] DRAM_rdata = '0;
   logic        DRAM_rvalid = 1'b0;
   logic        DRAM_wready = 1'b0;
   logic        busy;

   int n_pass = 0;
   int n_total = 0;
   int pulses;

   dram_arbiter #(.BURST_LEN(8), .CNT_W(4)) dut (
      .CLK(CLK), .RESET(RESET),
      .I_req(I_req), .I_addr(I_addr), .I_data(I_data), .I_valid(I_valid),
      .D_req(D_req), .D_we(D_we), .D_addr(D_addr), .D_wdata(D_wdata),
      .D_wnext(D_wnext), .D_data(D_data), .D_valid(D_valid),
      .DRAM_cmd(DRAM_cmd), .DRAM_we(DRAM_we), .DRAM_addr(DRAM_addr),
      .DRAM_wdata(DRAM_wdata), .DRAM_rdata(DRAM_rdata),
      .DRAM_rvalid(DRAM_rvalid), .DRAM_wready(DRAM_wready), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s got %h want %h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // One read beat; exp_d selects which side should see it.
   task automatic rbeat(input logic [31:0] d, input logic exp_d);
      DRAM_rvalid = 1'b1;
      DRAM_rdata  = d;
      #2;
      chk("rd_ivalid", {31'b0, I_valid}, {31'b0, ~exp_d});
      chk("rd_dvalid", {31'b0, D_valid}, {31'b0, exp_d});
      chk("rd_data", exp_d ? D_data : I_data, d);
      if (I_valid | D_valid) pulses++;
      tick();
      DRAM_rvalid = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      // reset values
      #2;
      chk("rst_cmd", {31'b0, DRAM_cmd}, 32'd0);
      chk("rst_we", {31'b0, DRAM_we}, 32'd0);
      chk("rst_addr", DRAM_addr, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_wnext", {31'b0, D_wnext}, 32'd0);
      tick();
      RESET = 1'b1;
      tick();
      tick();
      chk("no_cmd_after_rst", {31'b0, DRAM_cmd}, 32'd0);

      // rvalid in IDLE ignored
      DRAM_rvalid = 1'b1;
      #2;
      chk("idle_ivalid", {31'b0, I_valid}, 32'd0);
      chk("idle_dvalid", {31'b0, D_valid}, 32'd0);
      tick();
      DRAM_rvalid = 1'b0;
      chk("idle_cnt", {28'b0, dut.cnt}, 32'd0);

      // single I read at 0x40
      I_req  = 1'b1;
      I_addr = 32'h40;
      #2;
      chk("i_idle_busy", {31'b0, busy}, 32'd0);
      tick();
      chk("i_cmd", {31'b0, DRAM_cmd}, 32'd1);
      chk("i_addr", DRAM_addr, 32'h40);
      chk("i_we", {31'b0, DRAM_we}, 32'd0);
      chk("i_busy", {31'b0, busy}, 32'd1);
      tick();
      chk("i_cmd_one", {31'b0, DRAM_cmd}, 32'd0);
      pulses = 0;
      for (int i = 0; i < 8; i++) rbeat(32'hA000 + i, 1'b0);
      chk("i_pulses", pulses, 32'd8);
      // I_req still held: stay in RELEASE, no new command
      DRAM_rvalid = 1'b1;
      #2;
      chk("rel_ivalid", {31'b0, I_valid}, 32'd0);
      chk("rel_busy0", {31'b0, busy}, 32'd1);
      tick();
      DRAM_rvalid = 1'b0;
      chk("rel_cmd1", {31'b0, DRAM_cmd}, 32'd0);
      chk("rel_busy1", {31'b0, busy}, 32'd1);
      tick();
      chk("rel_cmd2", {31'b0, DRAM_cmd}, 32'd0);
      chk("rel_busy2", {31'b0, busy}, 32'd1);
      I_req = 1'b0;
      tick();
      chk("rel_idle", {31'b0, busy}, 32'd0);
      tick();
      chk("rel_nocmd", {31'b0, DRAM_cmd}, 32'd0);

      // tie after reset: D first, then I
      RESET = 1'b0;
      tick();
      RESET = 1'b1;
      tick();
      I_req  = 1'b1;
      I_addr = 32'h100;
      D_req  = 1'b1;
      D_we   = 1'b0;
      D_addr = 32'h200;
      tick();
      chk("tie_cmd", {31'b0, DRAM_cmd}, 32'd1);
      chk("tie_addr_d", DRAM_addr, 32'h200);
      chk("tie_we", {31'b0, DRAM_we}, 32'd0);
      tick();
      pulses = 0;
      for (int i = 0; i < 8; i++) rbeat(32'hB000 + i, 1'b1);
      chk("d_pulses", pulses, 32'd8);
      D_req = 1'b0;
      tick();
      chk("tie_idle", {31'b0, busy}, 32'd0);
      tick();
      chk("tie_cmd_i", {31'b0, DRAM_cmd}, 32'd1);
      chk("tie_addr_i", DRAM_addr, 32'h100);
      tick();
      pulses = 0;
      for (int i = 0; i < 8; i++) rbeat(32'hC000 + i, 1'b0);
      chk("i2_pulses", pulses, 32'd8);
      I_req = 1'b0;
      tick();

      // D write-back with wready toggling
      D_req  = 1'b1;
      D_we   = 1'b1;
      D_addr = 32'h300;
      tick();
      chk("w_cmd", {31'b0, DRAM_cmd}, 32'd1);
      chk("w_addr", DRAM_addr, 32'h300);
      chk("w_we", {31'b0, DRAM_we}, 32'd1);
      tick();
      pulses = 0;
      for (int k = 0; k < 15; k++) begin
         DRAM_wready = (k % 2 == 0);
         DRAM_rvalid = (k % 2 == 1);
         D_wdata     = 32'hD000 + k;
         #2;
         chk("w_wnext", {31'b0, D_wnext}, {31'b0, DRAM_wready});
         chk("w_wdata", DRAM_wdata, 32'hD000 + k);
         chk("w_no_dvalid", {31'b0, D_valid}, 32'd0);
         if (D_wnext) pulses++;
         tick();
      end
      DRAM_rvalid = 1'b0;
      chk("w_pulses", pulses, 32'd8);
      DRAM_wready = 1'b1;
      #2;
      chk("w_release", {31'b0, D_wnext}, 32'd0);
      chk("w_rel_busy", {31'b0, busy}, 32'd1);
      DRAM_wready = 1'b0;
      D_req = 1'b0;
      D_we  = 1'b0;
      tick();
      chk("w_idle", {31'b0, busy}, 32'd0);

      // async reset after beat 4, then full service
      I_req  = 1'b1;
      I_addr = 32'h500;
      tick();
      tick();
      for (int i = 0; i < 4; i++) rbeat(32'hE000 + i, 1'b0);
      #1;
      RESET = 1'b0;
      #1;
      chk("ar_busy", {31'b0, busy}, 32'd0);
      chk("ar_cmd", {31'b0, DRAM_cmd}, 32'd0);
      chk("ar_addr", DRAM_addr, 32'd0);
      I_req  = 1'b0;
      tick();
      RESET = 1'b1;
      tick();
      chk("ar_nocmd", {31'b0, DRAM_cmd}, 32'd0);
      I_req  = 1'b1;
      I_addr = 32'h600;
      tick();
      chk("ar2_cmd", {31'b0, DRAM_cmd}, 32'd1);
      chk("ar2_addr", DRAM_addr, 32'h600);
      tick();
      pulses = 0;
      for (int i = 0; i < 8; i++) rbeat(32'hF000 + i, 1'b0);
      chk("ar2_pulses", pulses, 32'd8);
      DRAM_rvalid = 1'b1;
      #2;
      chk("ar2_release", {31'b0, I_valid}, 32'd0);
      DRAM_rvalid = 1'b0;
      I_req = 1'b0;
      tick();
      chk("ar2_idle", {31'b0, busy}, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
